// File: rtl/fft_power_acc.sv
// Per-channel power |X|^2 of a parallel FFT stream, integrated over acc_len spectra in block RAM.
// One integrated spectrum is dumped per integration, preceded by a one-cycle sync_out.
module fft_power_acc #(
  parameter int STREAMS   = 8,
  parameter int FFT_SIZE  = 1024,
  parameter int DIN_WIDTH = 36,
  parameter int ACC_WIDTH = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sync_in,
  input  logic [STREAMS*DIN_WIDTH-1:0] din,
  input  logic [31:0]                  acc_len,
  output logic                         sync_out,
  output logic [STREAMS*ACC_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic [31:0]                  acc_cnt,
  output logic                         ovf,
  output logic                         sync_err
);
  // state | meaning
  // IDLE  | waiting for the first sync_in, din ignored
  // ACC   | integrating spectra, dumping on the last one
  localparam int FFT_CYCLES = FFT_SIZE / STREAMS;
  localparam int BW = $clog2(FFT_CYCLES);
  localparam int HW = DIN_WIDTH / 2;
  localparam logic [BW-1:0] BIN_LAST = BW'(FFT_CYCLES - 1);

  typedef enum logic {IDLE, ACC} state_t;
  typedef struct packed {
    logic          v;
    logic          fst;
    logic          lst;
    logic [BW-1:0] bin;
  } tag_t;

  state_t state, state_nxt;
  logic acc_on;
  logic [BW-1:0] bin_cnt;
  logic [31:0] spec_cnt, len_q, len_cur;
  logic first_spec, last_spec, bin_wrap, sync_bad;
  tag_t t1, t2, t3;

  logic [STREAMS*DIN_WIDTH-1:0] din_q;
  logic signed [DIN_WIDTH-1:0] re_x [STREAMS];
  logic signed [DIN_WIDTH-1:0] im_x [STREAMS];
  logic [DIN_WIDTH-1:0] sq_re [STREAMS];
  logic [DIN_WIDTH-1:0] sq_im [STREAMS];
  logic [DIN_WIDTH-1:0] pow [STREAMS];
  logic [ACC_WIDTH:0] sum_w [STREAMS];
  logic [STREAMS*ACC_WIDTH-1:0] mem [FFT_CYCLES];
  logic [STREAMS*ACC_WIDTH-1:0] rd_q, sum_bus;
  logic any_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE && sync_in) state_nxt = ACC;
  end

  always_comb begin
    acc_on = (state == ACC);
  end

  // The integration length is taken from acc_len only on the first group of an integration.
  always_comb begin
    len_cur = len_q;
    if (spec_cnt == 32'd0 && bin_cnt == '0) len_cur = (acc_len == 32'd0) ? 32'd1 : acc_len;
    first_spec = (spec_cnt == 32'd0);
    last_spec  = (spec_cnt == len_cur - 32'd1);
    bin_wrap   = (bin_cnt == BIN_LAST);
    sync_bad   = acc_on && sync_in && !bin_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt  <= '0;
      spec_cnt <= '0;
      len_q    <= 32'd1;
      sync_err <= 1'b0;
    end else if (!acc_on) begin
      bin_cnt  <= '0;
      spec_cnt <= '0;
    end else begin
      len_q <= len_cur;
      if (sync_bad) begin
        sync_err <= 1'b1;
        bin_cnt  <= '0;
        spec_cnt <= '0;
      end else begin
        bin_cnt <= bin_cnt + 1'b1;
        if (bin_wrap) spec_cnt <= last_spec ? 32'd0 : spec_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < STREAMS; i++) begin
      re_x[i] = {{(DIN_WIDTH-HW){din_q[i*DIN_WIDTH+DIN_WIDTH-1]}}, din_q[i*DIN_WIDTH+HW +: HW]};
      im_x[i] = {{(DIN_WIDTH-HW){din_q[i*DIN_WIDTH+HW-1]}}, din_q[i*DIN_WIDTH +: HW]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1 <= '0;
      t2 <= '0;
      t3 <= '0;
      din_q <= '0;
      for (int i = 0; i < STREAMS; i++) begin
        sq_re[i] <= '0;
        sq_im[i] <= '0;
        pow[i]   <= '0;
      end
    end else begin
      t1 <= '{v: acc_on, fst: first_spec, lst: last_spec, bin: bin_cnt};
      t2 <= t1;
      t3 <= t2;
      din_q <= din;
      for (int i = 0; i < STREAMS; i++) begin
        sq_re[i] <= re_x[i] * re_x[i];
        sq_im[i] <= im_x[i] * im_x[i];
        pow[i]   <= sq_re[i] + sq_im[i];
      end
    end
  end

  // Same-bin read and write are a full spectrum apart, so no forwarding path is needed.
  always_ff @(posedge clk) begin
    if (t3.v) mem[t3.bin] <= sum_bus;
    rd_q <= mem[t2.bin];
  end

  always_comb begin
    sum_bus = '0;
    any_sat = 1'b0;
    for (int i = 0; i < STREAMS; i++) begin
      sum_w[i] = {1'b0, (t3.fst ? {ACC_WIDTH{1'b0}} : rd_q[i*ACC_WIDTH +: ACC_WIDTH])}
               + {{(ACC_WIDTH+1-DIN_WIDTH){1'b0}}, pow[i]};
      sum_bus[i*ACC_WIDTH +: ACC_WIDTH] = sum_w[i][ACC_WIDTH] ? {ACC_WIDTH{1'b1}}
                                                              : sum_w[i][ACC_WIDTH-1:0];
      any_sat = any_sat | sum_w[i][ACC_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_out   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      acc_cnt    <= '0;
      ovf        <= 1'b0;
    end else begin
      sync_out   <= t2.v && t2.lst && (t2.bin == '0);
      dout_valid <= t3.v && t3.lst;
      dout       <= (t3.v && t3.lst) ? sum_bus : '0;
      if (t3.v && t3.lst && t3.bin == BIN_LAST) acc_cnt <= acc_cnt + 32'd1;
      if (t3.v && any_sat) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_power_acc.sv
// Bench for fft_power_acc: per-channel integer reference model with expected outputs keyed by cycle.
module tb_fft_power_acc;
  localparam int S  = 8;
  localparam int FS = 64;
  localparam int DW = 36;
  localparam int AW = 36;
  localparam int FC = FS / S;
  localparam int HW = DW / 2;
  localparam longint unsigned AMAX = (64'd1 << AW) - 64'd1;
  localparam int M_CONST = 0, M_RAMP = 1, M_RAND = 2, M_MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sync_in = 1'b0;
  logic [S*DW-1:0] din = '0;
  logic [31:0] acc_len = 32'd4;
  logic sync_out, dout_valid, ovf, sync_err;
  logic [S*AW-1:0] dout;
  logic [31:0] acc_cnt;

  fft_power_acc #(.STREAMS(S), .FFT_SIZE(FS), .DIN_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .sync_in(sync_in), .din(din), .acc_len(acc_len),
    .sync_out(sync_out), .dout(dout), .dout_valid(dout_valid), .acc_cnt(acc_cnt),
    .ovf(ovf), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit m_run = 0;
  int m_pos = 0, m_spec = 0, m_len = 1;
  longint unsigned m_acc [FS];
  bit ev_valid [int];
  bit ev_sync [int];
  bit ev_inc [int];
  bit ev_ovf [int];
  bit ev_err [int];
  logic [S*AW-1:0] ev_dout [int];
  int exp_acc = 0;
  bit exp_ovf = 0, exp_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Spectrum bookkeeping in channel terms: one group of S channels per clock.
  task automatic model_step();
    logic signed [HW-1:0] re_v, im_v;
    longint r, m, p;
    logic [S*AW-1:0] bus;
    longint unsigned t;
    int ch;
    if (rst) begin
      m_run = 0;
      return;
    end
    if (!m_run) begin
      if (sync_in) begin
        m_run = 1; m_pos = 0; m_spec = 0;
      end
      return;
    end
    if (m_pos == 0 && m_spec == 0) m_len = (acc_len == 32'd0) ? 1 : int'(acc_len);
    bus = '0;
    for (int i = 0; i < S; i++) begin
      ch = m_pos * S + i;
      re_v = din[i*DW+HW +: HW];
      im_v = din[i*DW +: HW];
      r = re_v; m = im_v;
      p = r * r + m * m;
      if (m_spec == 0) m_acc[ch] = longint'(p);
      else begin
        m_acc[ch] = m_acc[ch] + longint'(p);
        if (m_acc[ch] > AMAX) begin
          m_acc[ch] = AMAX;
          ev_ovf[cyc+3] = 1;
        end
      end
      t = m_acc[ch];
      bus[i*AW +: AW] = t[AW-1:0];
    end
    if (m_spec == m_len - 1) begin
      ev_valid[cyc+3] = 1;
      ev_dout[cyc+3] = bus;
      if (m_pos == 0) ev_sync[cyc+2] = 1;
      if (m_pos == FC - 1) ev_inc[cyc+3] = 1;
    end
    if (sync_in && m_pos != FC - 1) begin
      ev_err[cyc] = 1;
      m_pos = 0; m_spec = 0;
    end else if (m_pos == FC - 1) begin
      m_pos = 0;
      m_spec = (m_spec == m_len - 1) ? 0 : m_spec + 1;
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_outputs();
    logic [S*AW-1:0] eb;
    logic [AW-1:0] got, want;
    bit v;
    if (ev_ovf.exists(cyc)) exp_ovf = 1;
    if (ev_err.exists(cyc)) exp_err = 1;
    if (ev_inc.exists(cyc)) exp_acc++;
    v = ev_valid.exists(cyc);
    chk_eq("dout_valid", dout_valid, v);
    chk_eq("sync_out", sync_out, ev_sync.exists(cyc));
    chk_eq("acc_cnt", acc_cnt, exp_acc);
    chk_eq("ovf", ovf, exp_ovf);
    chk_eq("sync_err", sync_err, exp_err);
    if (v) begin
      eb = ev_dout[cyc];
      for (int i = 0; i < S; i++) begin
        got = dout[i*AW +: AW];
        want = eb[i*AW +: AW];
        chk_eq($sformatf("dout_lane%0d", i), got, want);
      end
    end
    ev_valid.delete(cyc); ev_sync.delete(cyc); ev_inc.delete(cyc);
    ev_ovf.delete(cyc); ev_err.delete(cyc); ev_dout.delete(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_din(input int mode);
    int re, im;
    logic [31:0] rb, ib;
    for (int i = 0; i < S; i++) begin
      case (mode)
        M_CONST: begin re = 3; im = 4; end
        M_RAMP:  begin re = m_pos * S + i; im = 0; end
        M_MAX:   begin re = -131072; im = -131072; end
        default: begin
          re = int'($urandom_range(8191)) - 4096;
          im = int'($urandom_range(8191)) - 4096;
        end
      endcase
      rb = re; ib = im;
      din[i*DW +: DW] = {rb[HW-1:0], ib[HW-1:0]};
    end
  endtask

  // sync_mode: 0 none, 1 start plus every frame boundary, 2 start plus random boundaries
  task automatic run(input int n, input int mode, input int sync_mode);
    for (int k = 0; k < n; k++) begin
      sync_in = 1'b0;
      if (sync_mode != 0 && (!m_run ||
          (m_pos == FC - 1 && (sync_mode == 1 || $urandom_range(0, 1) == 1))))
        sync_in = 1'b1;
      set_din(mode);
      step();
    end
    sync_in = 1'b0;
  endtask

  task automatic run_until_valid(input int mode, input int max_cyc);
    for (int k = 0; k < max_cyc && !dout_valid; k++) run(1, mode, 0);
    chk_eq("wait_dout_valid", dout_valid, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sync_in = 1'b0;
    m_run = 0;
    ev_valid.delete(); ev_sync.delete(); ev_inc.delete();
    ev_ovf.delete(); ev_err.delete(); ev_dout.delete();
    exp_acc = 0; exp_ovf = 0; exp_err = 0;
    #1;
    chk_eq("rst_dout_valid", dout_valid, 0);
    chk_eq("rst_dout", {63'd0, |dout}, 0);
    chk_eq("rst_sync_out", sync_out, 0);
    chk_eq("rst_acc_cnt", acc_cnt, 0);
    chk_eq("rst_ovf", ovf, 0);
    chk_eq("rst_sync_err", sync_err, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    apply_reset();

    // constant 3+4j, four spectra per dump -> 100 per lane
    acc_len = 32'd4;
    run(1, M_CONST, 1);
    run_until_valid(M_CONST, 64);
    chk_eq("const_dout_lane0", dout[AW-1:0], 100);
    chk_eq("const_dout_lane7", dout[7*AW +: AW], 100);
    run(100, M_CONST, 1);
    run(40, M_CONST, 0);

    // ramp with single-spectrum integrations
    acc_len = 32'd1;
    run(40, M_RAMP, 1);
    acc_len = 32'd0;
    run(40, M_RAMP, 1);

    for (int r = 0; r < 6; r++) begin
      acc_len = $urandom_range(0, 5);
      run(90, M_RAND, 2);
    end

    // off-boundary sync in the second spectrum
    apply_reset();
    acc_len = 32'd4;
    run(1, M_RAND, 1);
    for (int k = 0; k < 200 && !(m_spec == 1 && m_pos == 3); k++) run(1, M_RAND, 0);
    sync_in = 1'b1;
    set_din(M_RAND);
    step();
    sync_in = 1'b0;
    chk_eq("bad_sync_err", sync_err, 1);
    run(160, M_RAND, 0);

    // acc_len change during an integration
    acc_len = 32'd4;
    run(12, M_RAND, 1);
    acc_len = 32'd2;
    run(160, M_RAND, 1);

    // saturation with full-scale negative inputs
    apply_reset();
    acc_len = 32'd4;
    run(1, M_MAX, 1);
    run_until_valid(M_MAX, 64);
    chk_eq("sat_dout_lane0", dout[AW-1:0], AMAX);
    chk_eq("sat_ovf", ovf, 1);
    run(60, M_RAND, 1);

    // reset in the middle of a dump
    acc_len = 32'd2;
    run_until_valid(M_RAND, 64);
    run(2, M_RAND, 0);
    #2;
    apply_reset();
    run(30, M_RAND, 0);
    run(80, M_RAND, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
